// File: rtl/fetch_queue_pkg.sv
// +--------------------------------------------------------------------------+
// | fetch_queue_pkg : shared constants and entry type for the fetch queue     |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

package fetch_queue_pkg;

  localparam logic [31:0] c_nop_word = 32'h0000_0000;
  localparam logic [31:0] c_reset_pc = 32'h0000_3000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc8;
  } fq_entry_t;

endpackage : fetch_queue_pkg

`default_nettype wire

// File: rtl/fetch_queue.sv
// +--------------------------------------------------------------------------+
// | fetch_queue : fetch-to-decode instruction buffer with branch flush        |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [31:0]   in_instr,
  input  logic [31:0]   in_pc8,
  output logic          in_ready,
  output logic          out_valid,
  output logic [31:0]   out_instr,
  output logic [31:0]   out_pc8,
  input  logic          out_ready,
  input  logic          flush,
  input  logic          flush_keep,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  fq_entry_t      mem_q [DEPTH];
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic [AW-1:0]  rd_post;
  logic [AW:0]    remain;
  logic           push, pop, mem_we;

  assign in_ready  = (count_q != FULL_COUNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign remain    = count_q - (AW+1)'(pop);
  assign rd_post   = rd_ptr_q + AW'(pop);
  assign count     = count_q;

  assign out_instr = out_valid ? mem_q[rd_ptr_q].instr : c_nop_word;
  assign out_pc8   = out_valid ? mem_q[rd_ptr_q].pc8   : c_nop_word;

  // Flush keeps at most the oldest survivor: a stored entry if any remain
  // after the pop, otherwise the incoming push.
  always_comb begin
    rd_ptr_d = rd_post;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    mem_we   = 1'b0;
    if (!flush) begin
      mem_we   = push;
      wr_ptr_d = wr_ptr_q + AW'(push);
      count_d  = remain + (AW+1)'(push);
    end else if (flush_keep && (remain != '0)) begin
      wr_ptr_d = rd_post + AW'(1);
      count_d  = (AW+1)'(1);
    end else if (flush_keep && push) begin
      mem_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + AW'(1);
      count_d  = (AW+1)'(1);
    end else begin
      wr_ptr_d = rd_post;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= '{instr: in_instr, pc8: in_pc8};
    end
  end

endmodule : fetch_queue

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// +--------------------------------------------------------------------------+
// | tb_fetch_queue : directed self-checking bench for fetch_queue             |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_fetch_queue;

  logic        clk;
  logic        clr;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc8;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc8;
  logic        out_ready;
  logic        flush;
  logic        flush_keep;
  logic [2:0]  count;

  int n_vec;
  int n_err;

  fetch_queue #(.DEPTH(4), .AW(2)) dut (
    .clk        (clk),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_instr   (in_instr),
    .in_pc8     (in_pc8),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_instr  (out_instr),
    .out_pc8    (out_pc8),
    .out_ready  (out_ready),
    .flush      (flush),
    .flush_keep (flush_keep),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w, input logic [31:0] p);
    in_valid = 1'b1;
    in_instr = w;
    in_pc8   = p;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    clr = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc8 = '0;
    out_ready = 1'b0; flush = 1'b0; flush_keep = 1'b0;

    // Power-on reset
    #2 clr = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_count",     64'(count),     64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    @(negedge clk);
    clr = 1'b1;
    tick();

    // One-cycle latency, no bypass
    in_valid = 1'b1; in_instr = 32'hDEAD_0001; in_pc8 = 32'h0000_3008;
    chk("lat_n_valid", 64'(out_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    chk("lat_n1_valid", 64'(out_valid), 64'd1);
    chk("lat_n1_instr", 64'(out_instr), 64'hDEAD_0001);
    chk("lat_n1_pc8",   64'(out_pc8),   64'h0000_3008);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("lat_drain_count", 64'(count), 64'd0);

    // Fill to DEPTH, ignored 5th push, ordered drain
    for (int i = 0; i < 4; i++) push_word(32'h2408_0001 + 32'(i), 32'h0000_3008 + 32'(4*i));
    chk("fill_count",    64'(count),    64'd4);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    push_word(32'h2408_0005, 32'h0000_3018);
    chk("fill_5th_count", 64'(count),     64'd4);
    chk("fill_5th_head",  64'(out_instr), 64'h2408_0001);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_instr", 64'(out_instr), 64'h2408_0001 + 64'(i));
      chk("drain_pc8",   64'(out_pc8),   64'h0000_3008 + 64'(4*i));
      tick();
    end
    out_ready = 1'b0;
    chk("drain_count", 64'(count),     64'd0);
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_nop",   64'(out_instr), 64'd0);

    // Simultaneous push/pop at count=2 across pointer wrap
    push_word(32'h0000_0100, 32'h0000_4000);
    push_word(32'h0000_0101, 32'h0000_4004);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_instr = 32'h0000_0102 + 32'(i);
      in_pc8   = 32'h0000_4008 + 32'(4*i);
      chk("pp_head", 64'(out_instr), 64'h0000_0100 + 64'(i));
      tick();
      chk("pp_count", 64'(count), 64'd2);
    end
    in_valid = 1'b0;
    chk("pp_tail0", 64'(out_instr), 64'h0000_0108);
    tick();
    chk("pp_tail1", 64'(out_instr), 64'h0000_0109);
    chk("pp_tail1_pc8", 64'(out_pc8), 64'h0000_4024);
    tick();
    out_ready = 1'b0;
    chk("pp_empty", 64'(count), 64'd0);

    // Asynchronous reset mid-run
    for (int i = 0; i < 3; i++) push_word(32'h0000_0200 + 32'(i), 32'h0000_5000 + 32'(4*i));
    chk("mid_pre_count", 64'(count), 64'd3);
    #2 clr = 1'b0;
    #1;
    chk("mid_out_valid", 64'(out_valid), 64'd0);
    chk("mid_in_ready",  64'(in_ready),  64'd1);
    chk("mid_count",     64'(count),     64'd0);
    chk("mid_out_instr", 64'(out_instr), 64'd0);
    clr = 1'b1;
    tick();
    chk("mid_post_count", 64'(count), 64'd0);

    // Flush keep with stored survivors: A,B,C; pop A + push D -> only B
    push_word(32'h0000_000A, 32'h0000_6000);
    push_word(32'h0000_000B, 32'h0000_6004);
    push_word(32'h0000_000C, 32'h0000_6008);
    out_ready = 1'b1; flush = 1'b1; flush_keep = 1'b1;
    in_valid = 1'b1; in_instr = 32'h0000_000D; in_pc8 = 32'h0000_600C;
    tick();
    out_ready = 1'b0; flush = 1'b0; flush_keep = 1'b0; in_valid = 1'b0;
    chk("fk_count",     64'(count),     64'd1);
    chk("fk_head",      64'(out_instr), 64'h0000_000B);
    chk("fk_head_pc8",  64'(out_pc8),   64'h0000_6004);
    chk("fk_in_ready",  64'(in_ready),  64'd1);
    push_word(32'h0000_000E, 32'h0000_7000);
    out_ready = 1'b1;
    chk("fk_after_b", 64'(out_instr), 64'h0000_000B);
    tick();
    chk("fk_after_e", 64'(out_instr), 64'h0000_000E);
    tick();
    out_ready = 1'b0;
    chk("fk_empty", 64'(count), 64'd0);

    // Flush keep from empty: the push is the delay slot
    out_ready = 1'b1; flush = 1'b1; flush_keep = 1'b1;
    in_valid = 1'b1; in_instr = 32'h0000_000D; in_pc8 = 32'h0000_600C;
    tick();
    out_ready = 1'b0; flush = 1'b0; flush_keep = 1'b0; in_valid = 1'b0;
    chk("fke_count", 64'(count),     64'd1);
    chk("fke_head",  64'(out_instr), 64'h0000_000D);
    chk("fke_pc8",   64'(out_pc8),   64'h0000_600C);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("fke_empty", 64'(count), 64'd0);

    // Flush with nothing stored and no push: no effect
    flush = 1'b1; flush_keep = 1'b1;
    tick();
    flush = 1'b0; flush_keep = 1'b0;
    chk("fidle_count", 64'(count), 64'd0);

    // Flush no-keep at count=3 with a valid push
    for (int i = 0; i < 3; i++) push_word(32'h0000_0300 + 32'(i), 32'h0000_8000 + 32'(4*i));
    flush = 1'b1; flush_keep = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0000_0399; in_pc8 = 32'h0000_8FFC;
    chk("fnk_in_ready_same", 64'(in_ready), 64'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fnk_count",     64'(count),     64'd0);
    chk("fnk_out_instr", 64'(out_instr), 64'd0);
    chk("fnk_out_pc8",   64'(out_pc8),   64'd0);
    chk("fnk_in_ready",  64'(in_ready),  64'd1);
    push_word(32'h0000_0400, 32'h0000_9000);
    chk("fnk_repush_head",  64'(out_instr), 64'h0000_0400);
    chk("fnk_repush_count", 64'(count),     64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_fetch_queue

`default_nettype wire
